// File: rtl/alu_mult_div_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: ops, states and default latencies.
package alu_mult_div_seq_pkg;

  // Operation encodings as presented on req_op
  localparam logic [1:0] OpMulu = 2'd0;
  localparam logic [1:0] OpMuls = 2'd1;
  localparam logic [1:0] OpDivu = 2'd2;
  localparam logic [1:0] OpDivs = 2'd3;

  // Sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Default pipeline depths of alu_mult_div
  localparam int unsigned DefaultMultLatency = 18;
  localparam int unsigned DefaultDivLatency  = 30;

  // Divides are the ops with the high encoding bit set
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_mult_div_format.sv
// Combinational 68000-style formatting of raw alu_mult_div results into result and {N,Z,V,C}.
module alu_mult_div_format
  import alu_mult_div_seq_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] mulu_result,
  input  logic [31:0] muls_result,
  input  logic [31:0] divu_quotient,
  input  logic [15:0] divu_remainder,
  input  logic [31:0] divs_quotient,
  input  logic [15:0] divs_remainder,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        overflow;

  // Select the raw result for the op, detect divide overflow, then pack result and flags
  always_comb begin
    result    = '0;
    flags     = '0;
    quotient  = '0;
    remainder = '0;
    overflow  = 1'b0;

    unique case (op)
      OpMulu: result = mulu_result;
      OpMuls: result = muls_result;
      OpDivu: begin
        quotient  = divu_quotient;
        remainder = divu_remainder;
        overflow  = (divu_quotient > 32'h0000_ffff);
      end
      OpDivs: begin
        quotient  = divs_quotient;
        remainder = divs_remainder;
        overflow  = ($signed(divs_quotient) > 32'sd32767) ||
                    ($signed(divs_quotient) < -32'sd32768);
      end
      default: result = '0;
    endcase

    if (op_is_div(op)) begin
      if (overflow) begin
        // Destination is left untouched on overflow; only V is reported
        result = dividend;
        flags  = 4'b0010;
      end else begin
        result = {remainder, quotient[15:0]};
        flags  = {quotient[15], (quotient[15:0] == 16'h0000), 2'b00};
      end
    end else begin
      flags = {result[31], (result == 32'h0000_0000), 2'b00};
    end
  end

endmodule

// File: rtl/alu_mult_div_seq.sv
// Issue-side sequencer for alu_mult_div: holds operands, waits the pipeline latency,
// captures and formats the result, and presents it over a valid/ready response.
module alu_mult_div_seq
  import alu_mult_div_seq_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = DefaultMultLatency,
  parameter int unsigned DIV_LATENCY  = DefaultDivLatency
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_operand1,
  input  logic [31:0] req_operand2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        resp_div_zero,
  output logic [31:0] md_operand1,
  output logic [31:0] md_operand2,
  input  logic [31:0] md_divu_quotient,
  input  logic [15:0] md_divu_remainder,
  input  logic [31:0] md_divs_quotient,
  input  logic [15:0] md_divs_remainder,
  input  logic [31:0] md_mulu_result,
  input  logic [31:0] md_muls_result
);

  localparam int unsigned MaxLatency = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int unsigned CntW       = $clog2(MaxLatency + 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      op_q;
  logic            div_zero_q;
  logic            accept;
  logic            div_zero_req;
  logic            capture;
  logic [31:0]     fmt_result;
  logic [3:0]      fmt_flags;

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = (state_q == StDone);
  assign accept       = req_valid && req_ready;
  assign div_zero_req = op_is_div(req_op) && (req_operand2[15:0] == 16'h0000);
  assign capture      = (state_q == StWait) && (count_q == '0);

  // Next-state and latency counter; divide-by-zero passes through WAIT with a zero count
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          if (div_zero_req) begin
            count_d = '0;
          end else if (op_is_div(req_op)) begin
            count_d = CntW'(DIV_LATENCY);
          end else begin
            count_d = CntW'(MULT_LATENCY);
          end
        end
      end
      StWait: begin
        if (count_q == '0) begin
          state_d = StDone;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Operand hold registers; held until the next accept so the pipeline never sees stale inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q        <= OpMulu;
      div_zero_q  <= 1'b0;
      md_operand1 <= '0;
      md_operand2 <= '0;
    end else if (accept) begin
      op_q        <= req_op;
      div_zero_q  <= div_zero_req;
      md_operand1 <= req_operand1;
      md_operand2 <= req_operand2;
    end
  end

  alu_mult_div_format u_format (
    .op             (op_q),
    .dividend       (md_operand1),
    .mulu_result    (md_mulu_result),
    .muls_result    (md_muls_result),
    .divu_quotient  (md_divu_quotient),
    .divu_remainder (md_divu_remainder),
    .divs_quotient  (md_divs_quotient),
    .divs_remainder (md_divs_remainder),
    .result         (fmt_result),
    .flags          (fmt_flags)
  );

  // Response registers, loaded once at capture and held through DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_result   <= '0;
      resp_flags    <= '0;
      resp_div_zero <= 1'b0;
    end else if (capture) begin
      resp_div_zero <= div_zero_q;
      if (div_zero_q) begin
        resp_result <= md_operand1;
        resp_flags  <= '0;
      end else begin
        resp_result <= fmt_result;
        resp_flags  <= fmt_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_div_seq.sv
// Self-checking bench for alu_mult_div_seq with a behavioural alu_mult_div pipeline model.
module tb_alu_mult_div_seq;

  localparam int MULT_LAT = 18;
  localparam int DIV_LAT  = 30;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_operand1;
  logic [31:0] req_operand2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [3:0]  resp_flags;
  logic        resp_div_zero;
  logic [31:0] md_operand1;
  logic [31:0] md_operand2;
  logic [31:0] md_divu_quotient;
  logic [15:0] md_divu_remainder;
  logic [31:0] md_divs_quotient;
  logic [15:0] md_divs_remainder;
  logic [31:0] md_mulu_result;
  logic [31:0] md_muls_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  alu_mult_div_seq #(
    .MULT_LATENCY (MULT_LAT),
    .DIV_LATENCY  (DIV_LAT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_operand1      (req_operand1),
    .req_operand2      (req_operand2),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_result       (resp_result),
    .resp_flags        (resp_flags),
    .resp_div_zero     (resp_div_zero),
    .md_operand1       (md_operand1),
    .md_operand2       (md_operand2),
    .md_divu_quotient  (md_divu_quotient),
    .md_divu_remainder (md_divu_remainder),
    .md_divs_quotient  (md_divs_quotient),
    .md_divs_remainder (md_divs_remainder),
    .md_mulu_result    (md_mulu_result),
    .md_muls_result    (md_muls_result)
  );

  // Behavioural alu_mult_div: raw results delayed by exactly the pipeline depths
  logic [31:0] mulu_pipe [MULT_LAT];
  logic [31:0] muls_pipe [MULT_LAT];
  logic [31:0] divu_q_pipe [DIV_LAT];
  logic [15:0] divu_r_pipe [DIV_LAT];
  logic [31:0] divs_q_pipe [DIV_LAT];
  logic [15:0] divs_r_pipe [DIV_LAT];

  always @(posedge clock) begin : md_model
    longint ua, ub, sa, sb, uq, ur, sq, sr;
    ua = longint'(md_operand1);
    ub = longint'(md_operand2[15:0]);
    sa = longint'($signed(md_operand1));
    sb = longint'($signed(md_operand2[15:0]));
    uq = (ub == 0) ? 0 : ua / ub;
    ur = (ub == 0) ? 0 : ua % ub;
    sq = (sb == 0) ? 0 : sa / sb;
    sr = (sb == 0) ? 0 : sa % sb;
    mulu_pipe[0]   <= 32'(longint'(md_operand1[15:0]) * longint'(md_operand2[15:0]));
    muls_pipe[0]   <= 32'(longint'($signed(md_operand1[15:0])) * sb);
    divu_q_pipe[0] <= 32'(uq);
    divu_r_pipe[0] <= 16'(ur);
    divs_q_pipe[0] <= 32'(sq);
    divs_r_pipe[0] <= 16'(sr);
    for (int i = 1; i < MULT_LAT; i++) begin
      mulu_pipe[i] <= mulu_pipe[i-1];
      muls_pipe[i] <= muls_pipe[i-1];
    end
    for (int i = 1; i < DIV_LAT; i++) begin
      divu_q_pipe[i] <= divu_q_pipe[i-1];
      divu_r_pipe[i] <= divu_r_pipe[i-1];
      divs_q_pipe[i] <= divs_q_pipe[i-1];
      divs_r_pipe[i] <= divs_r_pipe[i-1];
    end
  end

  assign md_mulu_result    = mulu_pipe[MULT_LAT-1];
  assign md_muls_result    = muls_pipe[MULT_LAT-1];
  assign md_divu_quotient  = divu_q_pipe[DIV_LAT-1];
  assign md_divu_remainder = divu_r_pipe[DIV_LAT-1];
  assign md_divs_quotient  = divs_q_pipe[DIV_LAT-1];
  assign md_divs_remainder = divs_r_pipe[DIV_LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: 68000 MULU/MULS/DIVU/DIVS semantics from plain 64-bit arithmetic
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic [3:0] fl, output logic dz);
    longint p, q, r, dv, ds;
    logic   ovf;
    dz  = 1'b0;
    fl  = 4'b0000;
    res = 32'h0;
    if (op < 2) begin
      if (op == 0) p = longint'(a[15:0]) * longint'(b[15:0]);
      else         p = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
      res = 32'(p);
      fl  = {res[31], (res == 32'h0), 2'b00};
    end else if (b[15:0] == 16'h0) begin
      dz  = 1'b1;
      res = a;
    end else begin
      if (op == 2) begin
        dv = longint'(a);
        ds = longint'(b[15:0]);
      end else begin
        dv = longint'($signed(a));
        ds = longint'($signed(b[15:0]));
      end
      q   = dv / ds;
      r   = dv % ds;
      ovf = (op == 2) ? (q > 65535) : (q > 32767 || q < -32768);
      if (ovf) begin
        res = a;
        fl  = 4'b0010;
      end else begin
        res = {16'(r), 16'(q)};
        fl  = {res[15], (res[15:0] == 16'h0), 2'b00};
      end
    end
  endfunction

  // One full transaction: accept, latency, formatted response, hold while stalled, release
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl,
                        input logic exp_dz, input int hold);
    int n;
    int exp_lat;
    exp_lat = exp_dz ? 1 : ((op >= 2) ? DIV_LAT + 1 : MULT_LAT + 1);
    @(negedge clock);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_operand1 = a;
    req_operand2 = b;
    resp_ready   = 1'b0;
    @(negedge clock);
    req_valid    = 1'b0;
    req_op       = 2'($urandom);
    req_operand1 = $urandom;
    req_operand2 = $urandom;
    check_eq("md_operand1", md_operand1, a);
    check_eq("md_operand2", md_operand2, b);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_eq("latency", 32'(n), 32'(exp_lat));
    check_eq("result", resp_result, exp_res);
    check_eq("flags", 32'(resp_flags), 32'(exp_fl));
    check_eq("div_zero", 32'(resp_div_zero), 32'(exp_dz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_result", resp_result, exp_res);
      check_eq("hold_flags", 32'(resp_flags), 32'(exp_fl));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check_eq("valid_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    logic        edz;
    int          t, first, second;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_op       = 2'd0;
    req_operand1 = 32'h0;
    req_operand2 = 32'h0;
    resp_ready   = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_result", resp_result, 32'h0);
    check_eq("rst_flags", 32'(resp_flags), 32'h0);
    check_eq("rst_div_zero", 32'(resp_div_zero), 32'h0);
    check_eq("rst_md_op1", md_operand1, 32'h0);
    check_eq("rst_md_op2", md_operand2, 32'h0);
    reset = 1'b0;

    // Directed cases with hand-computed expectations
    run_op(2'd0, 32'h0000_ffff, 32'h0000_ffff, 32'hfffe_0001, 4'b1000, 1'b0, 0);
    run_op(2'd1, 32'h0000_ffff, 32'h0000_0002, 32'hffff_fffe, 4'b1000, 1'b0, 1);
    run_op(2'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 4'b0100, 1'b0, 0);
    run_op(2'd2, 32'd100000,    32'd3,         32'h0001_8235, 4'b1000, 1'b0, 0);
    run_op(2'd3, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd, 4'b1000, 1'b0, 0);
    run_op(2'd2, 32'h0010_0000, 32'h0000_0001, 32'h0010_0000, 4'b0010, 1'b0, 0);
    run_op(2'd3, 32'h0001_0000, 32'h0000_0001, 32'h0001_0000, 4'b0010, 1'b0, 0);
    run_op(2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000, 1'b1, 2);
    run_op(2'd3, 32'hffff_0000, 32'h0005_0000, 32'hffff_0000, 4'b0000, 1'b1, 0);

    // Reset while an operation is in flight: no response, then a clean new op
    @(negedge clock);
    req_valid    = 1'b1;
    req_op       = 2'd0;
    req_operand1 = 32'h0000_ffff;
    req_operand2 = 32'h0000_ffff;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("abort_req_ready", 32'(req_ready), 32'd1);
    check_eq("abort_md_op1", md_operand1, 32'h0);
    repeat (25) @(negedge clock);
    check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
    run_op(2'd0, 32'd3, 32'd4, 32'd12, 4'b0000, 1'b0, 5);

    // Back-to-back throughput with the consumer always ready
    @(negedge clock);
    req_valid    = 1'b1;
    resp_ready   = 1'b1;
    req_op       = 2'd0;
    req_operand1 = 32'd2;
    req_operand2 = 32'd3;
    t      = 0;
    first  = -1;
    second = -1;
    while (second < 0 && t < 200) begin
      if (req_ready) begin
        if (first < 0) first = t;
        else           second = t;
      end
      if (second < 0) begin
        @(negedge clock);
        t++;
      end
    end
    check_eq("throughput", 32'(second - first), 32'(MULT_LAT + 3));
    @(negedge clock);
    req_valid = 1'b0;
    repeat (MULT_LAT + 5) @(negedge clock);
    resp_ready = 1'b0;
    check_eq("tp_idle", 32'(req_ready), 32'd1);

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      int sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b[15:0] = 16'h0;
      if (op >= 2 && sel == 1) a = a >> $urandom_range(8, 24);
      if (op >= 2 && sel == 2) a = -(a >> 16);
      if (op >= 2 && sel == 3) a = a >> 20;
      ref_model(op, a, b, er, ef, edz);
      run_op(op, a, b, er, ef, edz, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mult_div_seq.md
# alu_mult_div_seq

Issuing-side sequencer for the pipelined multiply/divide unit `alu_mult_div`. It accepts a MULU/MULS/DIVU/DIVS request over a valid/ready handshake and drives and holds the operands to `alu_mult_div`. It waits a fixed pipeline latency, then captures the matching result and formats it to 68000 semantics, including the packed remainder:quotient result, the N/Z/V/C flags, and overflow and divide-by-zero handling. It sits between the ALU microcode control and `alu_mult_div`.

## Interface
Parameters:
- MULT_LATENCY, 18, pipeline depth of the multipliers in `alu_mult_div`
- DIV_LATENCY, 30, pipeline depth of the dividers in `alu_mult_div`

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle; reset value 1
- req_op  in  2  operation: 0 MULU, 1 MULS, 2 DIVU, 3 DIVS
- req_operand1  in  32  dividend (div) or multiplicand in [15:0] (mul)
- req_operand2  in  32  divisor or multiplier in [15:0]; [31:16] ignored
- resp_valid  out  1  response held until taken; reset value 0
- resp_ready  in  1  consumer accepts response
- resp_result  out  32  formatted result; reset value 0
- resp_flags  out  4  {N,Z,V,C}; reset value 0
- resp_div_zero  out  1  divide-by-zero trap request; reset value 0
- md_operand1, md_operand2  out  32 each  registered operands to `alu_mult_div`; reset value 0
- md_divu_quotient  in  32  from `alu_mult_div`
- md_divu_remainder  in  16  from `alu_mult_div`
- md_divs_quotient  in  32  from `alu_mult_div`
- md_divs_remainder  in  16  from `alu_mult_div`
- md_mulu_result  in  32  from `alu_mult_div`
- md_muls_result  in  32  from `alu_mult_div`

## Operation
- States: IDLE, WAIT, DONE. Reset forces IDLE from any state, clears the counter, and leaves all outputs at their reset values. An in-flight operation is discarded with no response.
- `req_ready` = (state == IDLE). Accept = `req_valid && req_ready`.
- On accept, latch the op and both operands into `md_operand1`/`md_operand2`. The operands are held stable until the next accept.
- Accept of DIVU or DIVS with `req_operand2[15:0] == 0` goes to DONE:
  - `resp_div_zero` = 1
  - `resp_result` = operand1
  - flags = 0
  - no wait
- Any other accept goes to WAIT, with the counter loaded with MULT_LATENCY or DIV_LATENCY by op.
- WAIT: the counter decrements each cycle. When it is 0, capture the results, format them, and go to DONE.
- DONE: `resp_valid` = 1. All response outputs are held while `resp_ready` = 0. On `resp_ready`, go to IDLE and drop `resp_valid`. A new request cannot be accepted in the same cycle.
- Formatting is all 32-bit; C = 0 always.
  - MULU/MULS: result = the 32-bit product. N = bit 31, Z = (result == 0), V = 0.
  - DIVU: overflow if quotient > 0xFFFF.
  - DIVS: overflow if the 32-bit signed quotient is outside −32768..32767.
  - Divide overflow: V = 1, result = operand1 unchanged, N = Z = 0.
  - Divide, no overflow: result = {remainder[15:0], quotient[15:0]}. N = quotient bit 15, Z = (quotient[15:0] == 0), V = 0.
  - DIVS remainder takes the sign of the dividend, as delivered by `alu_mult_div`.

## Timing
- Accept at edge 0. `md_operand*` are valid after edge 0.
- Capture at edge LAT+1 (19 for mul, 31 for div). `resp_valid` is high after that edge.
- Divide-by-zero: `resp_valid` is high after edge 1.
- Back-to-back throughput: one operation per LAT+3 cycles with `resp_ready` tied high.
- The counter restarts on every accept. Stale pipeline contents from an operation aborted by reset are never captured, because operands are held through the full latency.

## Structure
- A shared defines file holds the op encodings (MULU, MULS, DIVU, DIVS), the state encodings, and the default latency constants.
- One natural sub-module: `alu_mult_div_format`. It is combinational: op plus the raw `md_*` results in, result and flags out. It is reused by the ALU flag logic.
- Instantiation of `alu_mult_div` stays outside this block.
- The bench uses a behavioural model of `alu_mult_div` with exactly MULT_LATENCY and DIV_LATENCY.

## Test plan
- MULU 0xFFFF × 0xFFFF → `resp_result` 0xFFFE0001, flags N=1 Z=0 V=0 C=0, `resp_valid` after edge 19.
- MULS 0xFFFF × 0x0002 → 0xFFFFFFFE, N=1; then MULU 0 × 5 → 0, Z=1.
- DIVU 100000 / 3 → 0x00018235 (remainder 1, quotient 33333), N=1 V=0, after edge 31; DIVS −7 / 2 → 0xFFFFFFFD, N=1.
- DIVU 0x00100000 / 1 → V=1, result 0x00100000; DIVS 0x00010000 / 1 → V=1.
- DIVU x / 0 → `resp_div_zero`=1 after edge 1, result = x.
- Reset mid-WAIT, then new MULU 3 × 4 → result 12 exactly at edge 19; `resp_ready` held low 5 cycles → outputs stable, `req_ready`=0 throughout.
